// File: rtl/ru_pkg.sv
// Shared types and constants for the RU mode controller.
package ru_pkg;

  // Default RU i_valid-to-o_valid latency and matching in-flight counter width.
  localparam int unsigned RU_LAT_DEF = 11;
  localparam int unsigned CNT_W_DEF  = 5;

  // Beat mode as carried on i_mode.
  typedef enum logic {
    MODE_EXP  = 1'b0,
    MODE_NORM = 1'b1
  } ru_mode_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ru_state_e;

  // RU datapath selects.
  typedef struct packed {
    logic sel_mux;
    logic sel_mult;
  } ru_sel_t;

  localparam ru_sel_t SEL_EXP  = '{sel_mux: 1'b1, sel_mult: 1'b1};
  localparam ru_sel_t SEL_NORM = '{sel_mux: 1'b0, sel_mult: 1'b0};

  // Mode-to-select mapping used by the controller.
  function automatic ru_sel_t mode_to_sel(input ru_mode_e mode);
    return (mode == MODE_EXP) ? SEL_EXP : SEL_NORM;
  endfunction

endpackage

// File: rtl/ru_credit_cnt.sv
// Saturating-at-zero up/down counter of beats in flight inside the RU.
module ru_credit_cnt #(
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned MAX_CNT = 11
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero_next,
  output logic             o_underflow
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_zero;
  logic             w_dec_eff;

  // A result with nothing in flight is spurious: it is flagged, never counted.
  assign w_zero      = (r_count == '0);
  assign w_dec_eff   = i_dec && !w_zero;
  assign o_underflow = i_dec && w_zero;

  // Next count; simultaneous issue and return cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (i_inc && !w_dec_eff) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!i_inc && w_dec_eff) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_count     = r_count;
  assign o_zero_next = (w_count_nxt == '0);

  // The RU pipeline can hold at most MAX_CNT beats; growing past that means a lost result.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_inc && !w_dec_eff && (r_count >= CNT_W'(MAX_CNT))));

endmodule

// File: rtl/ru_mode_ctrl.sv
// Issues requester beats to the RU, switching the RU mode only once its pipeline is empty.
module ru_mode_ctrl
  import ru_pkg::*;
#(
  parameter int unsigned RU_LAT = RU_LAT_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_mode,
  input  logic        i_last,
  input  logic [31:0] i_in0,
  input  logic [15:0] i_in1,
  output logic        o_ru_en,
  output logic        o_ru_valid,
  output logic [31:0] o_ru_in0,
  output logic [15:0] o_ru_in1,
  output logic        o_ru_sel_mux,
  output logic        o_ru_sel_mult,
  input  logic        i_ru_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  ru_state_e        r_state;
  ru_state_e        w_state_nxt;
  ru_mode_e         r_cur_mode;
  ru_mode_e         w_cur_mode_nxt;
  logic             r_last_seen;
  logic             w_last_seen_nxt;
  logic             r_err;
  logic             w_done;
  logic             w_ready;
  logic             w_issue;
  logic             w_mode_match;
  logic [CNT_W-1:0] w_count;
  logic             w_zero_next;
  logic             w_underflow;
  ru_sel_t          w_sel;

  assign w_mode_match = (ru_mode_e'(i_mode) == r_cur_mode);

  // Beats are only accepted while running in the matching mode.
  assign w_ready = (r_state == ST_RUN) && w_mode_match && !i_rst;
  assign w_issue = i_valid && w_ready;

  // Beats in flight inside the RU.
  ru_credit_cnt #(
    .CNT_W   (CNT_W),
    .MAX_CNT (RU_LAT)
  ) u_cnt (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_inc       (w_issue),
    .i_dec       (i_ru_valid),
    .o_count     (w_count),
    .o_zero_next (w_zero_next),
    .o_underflow (w_underflow)
  );

  // Next state, mode latch and completion pulse.
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_mode_nxt  = r_cur_mode;
    w_last_seen_nxt = r_last_seen;
    w_done          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Mode is only reloaded with an empty pipeline; this cycle is the bubble.
        if (i_valid && (w_count == '0)) begin
          w_cur_mode_nxt = ru_mode_e'(i_mode);
          w_state_nxt    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_valid) begin
          if (!w_mode_match) begin
            w_state_nxt = ST_DRAIN;
          end else if (i_last) begin
            w_last_seen_nxt = 1'b1;
            w_state_nxt     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Post-update count, so the final result leaves DRAIN on the next edge.
        if (w_zero_next) begin
          w_state_nxt     = ST_IDLE;
          w_done          = r_last_seen;
          w_last_seen_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (i_rst) begin
      w_done = 1'b0;
    end
  end

  // State, mode, last flag and sticky error registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cur_mode  <= MODE_EXP;
      r_last_seen <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_mode  <= w_cur_mode_nxt;
      r_last_seen <= w_last_seen_nxt;
      r_err       <= r_err | w_underflow;
    end
  end

  assign w_sel = mode_to_sel(r_cur_mode);

  assign o_ready       = w_ready;
  assign o_ru_en       = !i_rst;
  assign o_ru_valid    = w_issue;
  assign o_ru_in0      = i_in0;
  assign o_ru_in1      = i_in1;
  assign o_ru_sel_mux  = w_sel.sel_mux;
  assign o_ru_sel_mult = w_sel.sel_mult;
  assign o_busy        = (r_state != ST_IDLE) || (w_count != '0);
  assign o_done        = w_done;
  assign o_err         = r_err;

  // The selects must never move while a beat is inside the RU.
  a_mode_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (w_count != '0) |=> $stable(r_cur_mode));

endmodule

// File: tb/tb_ru_mode_ctrl.sv
// Scoreboard bench for ru_mode_ctrl with a fixed-latency RU model.
module tb_ru_mode_ctrl;

  localparam int unsigned L  = 11;
  localparam int unsigned CW = 5;
  localparam logic EXP  = 1'b0;
  localparam logic NORM = 1'b1;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_mode;
  logic        i_last;
  logic [31:0] i_in0;
  logic [15:0] i_in1;
  logic        o_ru_en;
  logic        o_ru_valid;
  logic [31:0] o_ru_in0;
  logic [15:0] o_ru_in1;
  logic        o_ru_sel_mux;
  logic        o_ru_sel_mult;
  logic        i_ru_valid;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  ru_mode_ctrl #(.RU_LAT(L), .CNT_W(CW)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_mode        (i_mode),
    .i_last        (i_last),
    .i_in0         (i_in0),
    .i_in1         (i_in1),
    .o_ru_en       (o_ru_en),
    .o_ru_valid    (o_ru_valid),
    .o_ru_in0      (o_ru_in0),
    .o_ru_in1      (o_ru_in1),
    .o_ru_sel_mux  (o_ru_sel_mux),
    .o_ru_sel_mult (o_ru_sel_mult),
    .i_ru_valid    (i_ru_valid),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // RU model: each issued beat returns exactly L cycles later; reset flushes it.
  logic [L-1:0] ru_sr;
  logic         inject;
  assign i_ru_valid = ru_sr[L-1] | inject;
  always @(posedge i_clk) begin
    if (i_rst) ru_sr <= '0;
    else       ru_sr <= {ru_sr[L-2:0], o_ru_valid};
  end

  // Reference in-flight count.
  int mdl_cnt = 0;
  always @(posedge i_clk) begin
    if (i_rst) mdl_cnt <= 0;
    else if (o_ru_valid && !i_ru_valid) mdl_cnt <= mdl_cnt + 1;
    else if (!o_ru_valid && i_ru_valid && mdl_cnt > 0) mdl_cnt <= mdl_cnt - 1;
  end

  typedef struct {
    logic [31:0] in0;
    logic [15:0] in1;
    logic        mode;
    int          cyc;
  } beat_t;

  beat_t iss_q[$];
  int    done_q[$];
  int    n_pass = 0;
  int    n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops expected issues and done pulses as the DUT presents them.
  beat_t mb;
  int    md;
  logic  prev_mux = 1'b1;
  logic  prev_mult = 1'b1;
  always @(negedge i_clk) begin
    if (o_ru_valid) begin
      if (iss_q.size() == 0) begin
        check("issue_unexpected", 1, 0);
      end else begin
        mb = iss_q.pop_front();
        check("issue_in0", o_ru_in0, mb.in0);
        check("issue_in1", o_ru_in1, mb.in1);
        check("issue_sel_mux",  o_ru_sel_mux,  (mb.mode == EXP) ? 1 : 0);
        check("issue_sel_mult", o_ru_sel_mult, (mb.mode == EXP) ? 1 : 0);
        if (mb.cyc >= 0) check("issue_cycle", cyc, mb.cyc);
      end
    end
    if (o_done) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        md = done_q.pop_front();
        if (md >= 0) check("done_cycle", cyc, md);
      end
    end
    if (!i_rst) begin
      if (o_ru_sel_mux != prev_mux || o_ru_sel_mult != prev_mult)
        check("sel_change_inflight", mdl_cnt, 0);
      prev_mux  = o_ru_sel_mux;
      prev_mult = o_ru_sel_mult;
    end
  end

  // Present one beat from a cycle start and hold it until accepted.
  task automatic present(input logic mode, input logic last, input logic [31:0] d0,
                         input logic [15:0] d1, input int exp_cyc);
    beat_t b;
    logic  acc;
    b.in0 = d0; b.in1 = d1; b.mode = mode; b.cyc = exp_cyc;
    iss_q.push_back(b);
    i_valid = 1'b1; i_mode = mode; i_last = last; i_in0 = d0; i_in1 = d1;
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk); #1;
    end
    // Junk on the sideband while idle must be ignored.
    i_valid = 1'b0;
    i_mode  = 1'($urandom_range(0, 1));
    i_last  = 1'($urandom_range(0, 1));
    i_in0   = $urandom;
    i_in1   = 16'($urandom);
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (k < budget && (iss_q.size() != 0 || done_q.size() != 0 || o_busy)) begin
      @(posedge i_clk); #1;
      k++;
    end
    check("drain_timeout", k < budget ? 0 : 1, 0);
  endtask

  task automatic idle_until(input int target);
    while (cyc < target) begin
      @(posedge i_clk); #1;
    end
  endtask

  int c0;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_last = 1'b0;
    i_in0 = '0; i_in1 = '0; inject = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    // Reset state.
    check("rst_ready", o_ready, 0);
    check("rst_ru_valid", o_ru_valid, 0);
    check("rst_ru_en", o_ru_en, 0);
    check("rst_done", o_done, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("post_rst_ru_en", o_ru_en, 1);
    check("post_rst_busy", o_busy, 0);
    check("post_rst_err", o_err, 0);
    check("post_rst_sel_mux", o_ru_sel_mux, 1);
    check("post_rst_sel_mult", o_ru_sel_mult, 1);
    @(posedge i_clk); #1;

    // 8 EXP beats back to back, last on beat 8.
    c0 = cyc;
    done_q.push_back(c0 + 8 + L);
    for (int i = 0; i < 8; i++)
      present(EXP, (i == 7), 32'hA000_0000 + 32'(i), 16'h0100 + 16'(i), c0 + 1 + i);
    wait_drain(60);

    // 3 EXP then NORM: NORM waits for the EXP beats to drain plus the bubble.
    c0 = cyc;
    done_q.push_back(c0 + 18 + L);
    present(EXP,  1'b0, 32'h1111_0001, 16'h2201, c0 + 1);
    present(EXP,  1'b0, 32'h1111_0002, 16'h2202, c0 + 2);
    present(EXP,  1'b0, 32'h1111_0003, 16'h2203, c0 + 3);
    present(NORM, 1'b0, 32'h3333_0001, 16'h4401, c0 + 3 + L + 2);
    present(NORM, 1'b0, 32'h3333_0002, 16'h4402, c0 + 17);
    present(NORM, 1'b1, 32'h3333_0003, 16'h4403, c0 + 18);
    wait_drain(60);

    // Issue and result in the same cycle at count 4.
    c0 = cyc;
    done_q.push_back(c0 + 12 + L);
    for (int i = 0; i < 4; i++)
      present(EXP, 1'b0, 32'h5555_0000 + 32'(i), 16'h6600 + 16'(i), c0 + 1 + i);
    idle_until(c0 + 12);
    present(EXP, 1'b1, 32'h5555_00FF, 16'h66FF, c0 + 12);
    wait_drain(60);
    check("same_cycle_no_err", o_err, 0);

    // Spurious result at count 0.
    inject = 1'b1;
    @(posedge i_clk); #1;
    inject = 1'b0;
    @(negedge i_clk);
    check("spurious_err_set", o_err, 1);
    check("spurious_busy", o_busy, 0);
    repeat (5) @(posedge i_clk);
    #1;
    c0 = cyc;
    done_q.push_back(c0 + 2 + L);
    present(EXP, 1'b0, 32'h7777_0001, 16'h8801, c0 + 1);
    present(EXP, 1'b1, 32'h7777_0002, 16'h8802, c0 + 2);
    wait_drain(60);
    check("spurious_err_sticky", o_err, 1);

    // Reset at count 6 during RUN.
    c0 = cyc;
    for (int i = 0; i < 6; i++)
      present(EXP, 1'b0, 32'h9999_0000 + 32'(i), 16'hAA00 + 16'(i), c0 + 1 + i);
    i_rst = 1'b1;
    i_valid = 1'b1; i_mode = EXP; i_last = 1'b0;
    @(negedge i_clk);
    check("rst_mid_ready", o_ready, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_valid = 1'b0;
    @(negedge i_clk);
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_err", o_err, 0);
    check("rst_mid_ru_en", o_ru_en, 1);
    check("rst_mid_ready_after", o_ready, 0);
    repeat (20) @(posedge i_clk);
    #1;
    check("rst_mid_err_later", o_err, 0);
    check("rst_mid_idle_later", o_busy, 0);

    // Random gaps and modes.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge i_clk);
      #0;
      if (i == 39) done_q.push_back(-1);
      present(1'($urandom_range(0, 1)), (i == 39), $urandom, 16'($urandom), -1);
    end
    wait_drain(400);
    check("rand_err", o_err, 0);
    check("rand_inflight", mdl_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
